// File: rtl/multi_edge_interval_counter.sv
// Multi-channel pulse-width capture: each channel times NUM_INTERVALS consecutive
// input intervals in clk cycles after a start event, with a shared registered read port.
module multi_edge_interval_counter #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 32,
    parameter int NUM_INTERVALS = 3,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enable,
    input  logic                trig_enable,
    input  logic                trig_in,
    input  logic [CHANNELS-1:0] cfg_in_inv,
    input  logic                cfg_trig_out,
    input  logic [CHANNELS-1:0] gpio_in,
    output logic [CHANNELS-1:0] trig_out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] sat,
    input  logic [CH_W-1:0]     rd_chan,
    input  logic [2:0]          rd_idx,
    output logic [CNT_W-1:0]    rd_data
);

    localparam int IDX_W = (NUM_INTERVALS > 1) ? $clog2(NUM_INTERVALS) : 1;
    localparam logic [CH_W:0] CH_LIM  = (CH_W + 1)'(CHANNELS);
    localparam logic [3:0]    IDX_LIM = 4'(NUM_INTERVALS);

    typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

    logic [CNT_W-1:0] cnt_all_s [CHANNELS][NUM_INTERVALS];
    logic [CNT_W-1:0] rd_data_r;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic             meta_r, s_r, p_r;
        logic             rise_s, edge_s, start_s, clear_s, last_s, fire_s;
        state_t           state_r, state_nx_s;
        logic [IDX_W-1:0] k_r;
        logic [CNT_W-1:0] cnt_r [NUM_INTERVALS];
        logic             os_r, trig_r, busy_r, done_r, sat_r;

        assign clear_s = rst | ~enable[ch];
        assign rise_s  = s_r & ~p_r;
        assign edge_s  = s_r ^ p_r;
        assign start_s = trig_enable ? trig_in : rise_s;
        assign last_s  = (k_r == IDX_W'(NUM_INTERVALS - 1));

        // Input synchronizer and one-cycle delay for edge detection
        always_ff @(posedge clk) begin
            if (clear_s) begin
                meta_r <= 1'b0;
                s_r    <= 1'b0;
                p_r    <= 1'b0;
            end else begin
                meta_r <= gpio_in[ch] ^ cfg_in_inv[ch];
                s_r    <= meta_r;
                p_r    <= s_r;
            end
        end

        // Next-state and trigger-qualifying event decode
        always_comb begin
            state_nx_s = state_r;
            fire_s     = 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable[ch]) state_nx_s = ARMED;
                    else            state_nx_s = IDLE;
                end
                ARMED: begin
                    if (start_s) begin
                        state_nx_s = COUNT;
                        fire_s     = ~cfg_trig_out;
                    end else begin
                        state_nx_s = ARMED;
                    end
                end
                COUNT: begin
                    if (edge_s) begin
                        fire_s = cfg_trig_out & (k_r == {IDX_W{1'b0}});
                        if (last_s) state_nx_s = DONE;
                        else        state_nx_s = COUNT;
                    end else begin
                        state_nx_s = COUNT;
                    end
                end
                DONE:    state_nx_s = DONE;
                default: state_nx_s = IDLE;
            endcase
        end

        // State register, status flags and one-shot trigger output
        always_ff @(posedge clk) begin
            if (clear_s) begin
                state_r <= IDLE;
                os_r    <= 1'b0;
                trig_r  <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                state_r <= state_nx_s;
                trig_r  <= fire_s & ~os_r;
                os_r    <= os_r | fire_s;
                busy_r  <= (state_nx_s == COUNT);
                done_r  <= (state_nx_s == DONE);
            end
        end

        // Interval counters: load 1 at each interval start, saturate rather than wrap
        always_ff @(posedge clk) begin
            if (clear_s) begin
                for (int i = 0; i < NUM_INTERVALS; i++) cnt_r[i] <= {CNT_W{1'b0}};
                k_r   <= {IDX_W{1'b0}};
                sat_r <= 1'b0;
            end else if (state_r == ARMED && start_s) begin
                cnt_r[0] <= CNT_W'(1);
                k_r      <= {IDX_W{1'b0}};
            end else if (state_r == COUNT) begin
                if (edge_s) begin
                    if (!last_s) begin
                        k_r                     <= k_r + IDX_W'(1);
                        cnt_r[k_r + IDX_W'(1)]  <= CNT_W'(1);
                    end
                end else if (cnt_r[k_r] == {CNT_W{1'b1}}) begin
                    sat_r <= 1'b1;
                end else begin
                    cnt_r[k_r] <= cnt_r[k_r] + CNT_W'(1);
                end
            end
        end

        for (genvar i = 0; i < NUM_INTERVALS; i++) begin : g_out
            assign cnt_all_s[ch][i] = cnt_r[i];
        end

        assign trig_out[ch] = trig_r;
        assign busy[ch]     = busy_r;
        assign done[ch]     = done_r;
        assign sat[ch]      = sat_r;
    end

    // Registered readback; out-of-range channel or interval reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {CNT_W{1'b0}};
        end else if (({1'b0, rd_idx} < IDX_LIM) && ({1'b0, rd_chan} < CH_LIM)) begin
            rd_data_r <= cnt_all_s[rd_chan][rd_idx[IDX_W-1:0]];
        end else begin
            rd_data_r <= {CNT_W{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: tb/tb_multi_edge_interval_counter.sv
// Self-checking bench for multi_edge_interval_counter (3 channels, 8-bit counters, 3 intervals).
module tb_multi_edge_interval_counter;

    localparam int CH = 3;
    localparam int CW = 8;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] enable, cfg_in_inv, gpio_in;
    logic          trig_enable, trig_in, cfg_trig_out;
    logic [CH-1:0] trig_out, busy, done, sat;
    logic [1:0]    rd_chan;
    logic [2:0]    rd_idx;
    logic [CW-1:0] rd_data;

    int checks = 0;
    int errors = 0;
    int tcnt [CH];

    typedef struct {
        logic [1:0] chan;
        logic [2:0] idx;
        int         exp;
        string      name;
    } vec_t;

    vec_t  vq [$];
    int    exp_q [$];
    string name_q [$];

    multi_edge_interval_counter #(.CHANNELS(CH), .CNT_W(CW), .NUM_INTERVALS(NI)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig_enable(trig_enable),
        .trig_in(trig_in), .cfg_in_inv(cfg_in_inv), .cfg_trig_out(cfg_trig_out),
        .gpio_in(gpio_in), .trig_out(trig_out), .busy(busy), .done(done), .sat(sat),
        .rd_chan(rd_chan), .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) if (trig_out[i]) tcnt[i] = tcnt[i] + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a read, queue its expectation, compare when the registered data appears
    task automatic do_read(input logic [1:0] c, input logic [2:0] i, input int exp, input string name);
        rd_chan = c;
        rd_idx  = i;
        exp_q.push_back(exp);
        name_q.push_back(name);
        step(1);
        check(name_q.pop_front(), int'(rd_data), exp_q.pop_front());
    endtask

    task automatic add(input logic [1:0] c, input logic [2:0] i, input int exp, input string name);
        vec_t v;
        v.chan = c; v.idx = i; v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    task automatic run_vq();
        for (int n = 0; n < vq.size(); n++) do_read(vq[n].chan, vq[n].idx, vq[n].exp, vq[n].name);
        vq.delete();
    endtask

    task automatic clr_tcnt();
        for (int i = 0; i < CH; i++) tcnt[i] = 0;
    endtask

    task automatic rearm(input logic [CH-1:0] en);
        enable = '0;
        step(1);
        enable = en;
        step(3);
    endtask

    initial begin
        clr_tcnt();
        rst = 1'b1; enable = '0; cfg_in_inv = '0; gpio_in = '0;
        trig_enable = 1'b0; trig_in = 1'b0; cfg_trig_out = 1'b0;
        rd_chan = 2'd0; rd_idx = 3'd0;
        step(3);
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_sat", int'(sat), 0);
        check("reset_trig", int'(trig_out), 0);
        do_read(2'd0, 3'd0, 0, "reset_rd");

        // Non-trigger mode: high 10, low 7, high 4
        enable = 3'b111;
        step(3);
        gpio_in[0] = 1'b1; step(10);
        gpio_in[0] = 1'b0; step(7);
        gpio_in[0] = 1'b1; step(4);
        gpio_in[0] = 1'b0; step(6);
        check("t1_done0", int'(done[0]), 1);
        check("t1_busy0", int'(busy[0]), 0);
        check("t1_done1", int'(done[1]), 0);
        check("t1_trig_pulses", tcnt[0], 1);
        add(2'd0, 3'd0, 10, "t1_cnt0");
        add(2'd0, 3'd1, 7, "t1_cnt1");
        add(2'd0, 3'd2, 4, "t1_cnt2");
        add(2'd1, 3'd0, 0, "t1_ch1_idle");
        run_vq();

        // Trigger mode: edge seen 25 cycles after trigger, trig_out at end of interval 0
        trig_enable = 1'b1; cfg_trig_out = 1'b1;
        rearm(3'b001);
        clr_tcnt();
        trig_in = 1'b1; step(1);
        trig_in = 1'b0; step(22);
        check("t2_trig_before_end", tcnt[0], 0);
        gpio_in[0] = 1'b1; step(5);
        gpio_in[0] = 1'b0; step(6);
        check("t2_trig_pulses", tcnt[0], 1);
        check("t2_busy0", int'(busy[0]), 1);
        add(2'd0, 3'd0, 25, "t2_latency");
        add(2'd0, 3'd1, 5, "t2_cnt1");
        run_vq();
        gpio_in[0] = 1'b1; step(3);
        gpio_in[0] = 1'b0; step(5);
        check("t2_done0", int'(done[0]), 1);
        check("t2_trig_once", tcnt[0], 1);

        // Saturation: high 300 cycles on an 8-bit counter
        trig_enable = 1'b0; cfg_trig_out = 1'b0;
        rearm(3'b001);
        gpio_in[0] = 1'b1; step(300);
        gpio_in[0] = 1'b0; step(6);
        gpio_in[0] = 1'b1; step(2);
        gpio_in[0] = 1'b0; step(5);
        check("t3_sat0", int'(sat[0]), 1);
        check("t3_sat1", int'(sat[1]), 0);
        check("t3_done0", int'(done[0]), 1);
        add(2'd0, 3'd0, 255, "t3_cnt0_sat");
        add(2'd0, 3'd1, 6, "t3_cnt1");
        add(2'd0, 3'd2, 2, "t3_cnt2");
        run_vq();

        // Inverted input on channel 2: low pulse of 12
        enable = '0;
        cfg_in_inv = 3'b100; gpio_in = 3'b100;
        step(1);
        enable = 3'b111;
        step(3);
        gpio_in[2] = 1'b0; step(12);
        gpio_in[2] = 1'b1; step(6);
        check("t4_busy", int'(busy), 4);
        add(2'd2, 3'd0, 12, "t4_inv_cnt0");
        add(2'd0, 3'd0, 0, "t4_ch0_clear");
        add(2'd1, 3'd0, 0, "t4_ch1_clear");
        run_vq();

        // Enable dropped mid-count, then re-armed with a new pulse of 9
        enable = '0; cfg_in_inv = '0; gpio_in = '0;
        step(1);
        enable = 3'b001;
        step(3);
        gpio_in[0] = 1'b1; step(7);
        check("t5_busy_mid", int'(busy[0]), 1);
        enable = '0; gpio_in[0] = 1'b0; step(1);
        enable = 3'b001; step(1);
        check("t5_busy_cleared", int'(busy[0]), 0);
        check("t5_done_cleared", int'(done[0]), 0);
        do_read(2'd0, 3'd0, 0, "t5_cnt_cleared");
        step(2);
        gpio_in[0] = 1'b1; step(9);
        gpio_in[0] = 1'b0; step(6);
        add(2'd0, 3'd0, 9, "t5_cnt0");
        add(2'd0, 3'd3, 0, "rd_idx_out_of_range");
        add(2'd3, 3'd0, 0, "rd_chan_out_of_range");
        add(2'd0, 3'd7, 0, "rd_idx_max");
        add(2'd0, 3'd0, 9, "rd_latency_valid");
        run_vq();

        // Synchronous reset while counting
        check("t6_busy_before_rst", int'(busy[0]), 1);
        rst = 1'b1; step(1);
        rst = 1'b0;
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(done), 0);
        check("t6_sat", int'(sat), 0);
        check("t6_trig", int'(trig_out), 0);
        check("t6_rd_reg", int'(rd_data), 0);
        do_read(2'd0, 3'd0, 0, "t6_cnt_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_edge_interval_counter.md
# multi_edge_interval_counter

Parametrised, multi-channel successor to the single-input three-interval edge counter. Each channel measures a configurable number of consecutive pulse widths (high/low durations) of a GPIO input in clk cycles, optionally started by a shared trigger. Each channel can emit a one-shot trigger pulse. Captured results are read back through a registered read port, so the register/SCARF bridge sees a single data bus regardless of channel count.

## Interface
- CHANNELS, 4, number of independent input channels (1..16)
- CNT_W, 32, width of each interval counter (8..32)
- NUM_INTERVALS, 3, intervals captured per channel per arming (1..8)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  CHANNELS  per-channel arm; low clears that channel
- trig_enable  input  1  1: interval 0 starts on trig_in; 0: starts on input rising edge
- trig_in  input  1  shared trigger level, sampled each cycle
- cfg_in_inv  input  CHANNELS  per-channel input inversion before synchronizer
- cfg_trig_out  input  1  0: trig_out on start event; 1: trig_out on end of interval 0
- gpio_in  input  CHANNELS  asynchronous pad inputs
- trig_out  output  CHANNELS  one-cycle trigger pulse, at most once per arming
- busy  output  CHANNELS  channel in COUNT state
- done  output  CHANNELS  all NUM_INTERVALS captured
- sat  output  CHANNELS  sticky: some interval reached all-ones
- rd_chan  input  $clog2(CHANNELS) (min 1)  read channel select
- rd_idx  input  3  read interval select
- rd_data  output  CNT_W  registered readback of count[rd_chan][rd_idx]

## Operation
- Per channel: s = 2-flop sync of (gpio_in ^ cfg_in_inv); p = s delayed one cycle. rise = s & ~p; edge = s ^ p.
- Per-channel FSM: IDLE, ARMED, COUNT, DONE.
- Reset or enable=0: state IDLE, all counts 0, done/sat/busy/trig_out 0, one-shot cleared; sync flops reset to 0.
- IDLE -> ARMED when enable=1.
- ARMED -> COUNT on start event: trig_enable ? trig_in : rise. On that cycle count[0] <= 1 and the current index k <= 0.
- COUNT, no edge: count[k] increments; holds at all-ones and sets sat.
- COUNT, edge, k < NUM_INTERVALS-1: count[k] frozen, count[k+1] <= 1, k <= k+1.
- COUNT, edge, k = NUM_INTERVALS-1: count[k] frozen, -> DONE, done=1.
- Edges in the start cycle are ignored (they neither end nor restart interval 0).
- DONE: all counts held until enable=0.
- Non-trigger mode: interval 0 = high width, 1 = low width, alternating. Trigger mode: interval 0 = trigger-to-first-edge latency.
- trig_out: if the one-shot is clear and (cfg_trig_out=0 and start event) or (cfg_trig_out=1 and interval 0 ends), register trig_out=1 for one cycle and set the one-shot.
- Readout: rd_data <= (rd_idx < NUM_INTERVALS) ? count[rd_chan][rd_idx] : 0. rd_chan >= CHANNELS returns 0.
- Channels are fully independent apart from the shared trig_in, trig_enable and cfg_trig_out.

## Timing
- gpio_in to s: 2 cycles. s to count update: same clock edge (count/state registered from s, p).
- A synced high pulse of H cycles gives count = H. A low gap of L cycles gives L.
- trig_out is asserted the cycle after the qualifying event is visible on s/trig_in, and lasts 1 cycle.
- done/busy are registered; done rises the cycle after the terminating edge is seen.
- rd_data latency is 1 cycle from rd_chan/rd_idx.
- enable falling mid-COUNT: the next edge clears the channel. A re-enable one cycle later starts cleanly in ARMED.
- rst has priority over enable. rst mid-count clears everything on the next edge.
- Saturation: a counter never wraps. The interval still ends normally on its edge.

## Test plan
- Non-trig, NUM_INTERVALS=3, ch0 high 10 / low 7 / high 4 then low -> count = 10, 7, 4; done=1; trig_out (cfg 0) pulses once at the first rising edge.
- Trig mode, trig_in pulse, input rises 25 cycles later (synced) -> count[0]=25; with cfg_trig_out=1, trig_out pulses once after interval 0 ends.
- CNT_W=8, high for 300 cycles -> count[0]=255, sat=1, interval 1 starts on the falling edge.
- cfg_in_inv=1 on ch2 with a low pulse of 12 cycles -> count[0]=12; other channels are unaffected.
- enable dropped at count 5 then re-raised -> counts read 0, state ARMED, a new pulse of 9 -> count[0]=9; rst asserted mid-count clears all outputs.
- Read port: rd_idx=NUM_INTERVALS and rd_chan=CHANNELS -> rd_data=0; a valid select returns the count 1 cycle later.
